unidade_controle_multiciclo: RTL and testbench

Multi-cycle control unit for the 64-bit load/store datapath. It sequences each instruction through fetch, decode, execute, memory and write-back. It decodes the opcode, funct3 and funct7 fields of the current instruction word. It drives the datapath's register-write, memory-write, ULA-operation and mux-select controls, plus a program-counter advance strobe, so that the program counter advances exactly once per retired instruction.

---
 rtl/unidade_controle_multiciclo.sv | 238 +++++++++++++++++++++++
 tb/tb_unidade_controle_multiciclo.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_multiciclo.sv
// ---------------------------------------------------------------------------
// unidade_controle_multiciclo
//
// Multi-cycle control unit for the 64-bit load/store datapath. Each
// instruction walks FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH, and
// the program counter is advanced exactly once per retired instruction.
// Every output is a register (Moore style), so there is no combinational
// path from instrucao to any output.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   run            level; while low the FSM idles in FETCH
//   instrucao      instruction word addressed by the current PC
//   ri_en          loads the datapath instruction register
//   pc_en          one-cycle strobe advancing contador_programa
//   load_en        register-file write enable (WB only)
//   store_en       RAM write enable / S-type immediate select (MEM of STORE)
//   op_ula         00 add, 01 sub, 10 slt, 11 equ
//   operation_type 0 = memory data to write-back, 1 = ULA result
//   ula_entry      0 = immediate, 1 = rs2
//   halted         high in HALT
//   illegal        high in ERROR
//   retired        count of completed instructions (wraps)
// ---------------------------------------------------------------------------
module unidade_controle_multiciclo #(
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic [31:0]         instrucao,
    output logic                ri_en,
    output logic                pc_en,
    output logic                load_en,
    output logic                store_en,
    output logic [1:0]          op_ula,
    output logic                operation_type,
    output logic                ula_entry,
    output logic                halted,
    output logic                illegal,
    output logic [CNT_BITS-1:0] retired
);

    localparam logic [6:0]  OPC_R      = 7'b0110011;
    localparam logic [6:0]  OPC_I      = 7'b0010011;
    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
    localparam logic [31:0] INSTR_HALT = 32'h0000_0073;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT,
        ERROR
    } state_t;

    typedef enum logic [1:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE
    } class_t;

    state_t      state;
    class_t      cls;
    logic [31:0] instr_q;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    logic        dec_valid;
    logic        dec_halt;
    logic [1:0]  dec_op;
    logic        dec_ula_entry;
    logic        dec_op_type;
    class_t      dec_cls;

    assign opcode = instr_q[6:0];
    assign funct3 = instr_q[14:12];
    assign funct7 = instr_q[31:25];

    // Decoder works only on the private copy latched at the end of FETCH,
    // so the instruction memory is free to move on once ri_en has fired.
    always_comb begin
        dec_valid     = 1'b0;
        dec_halt      = 1'b0;
        dec_op        = 2'b00;
        dec_ula_entry = 1'b0;
        dec_op_type   = 1'b0;
        dec_cls       = CLS_ALU;
        case (opcode)
            OPC_R: begin
                dec_cls       = CLS_ALU;
                dec_ula_entry = 1'b1;
                dec_op_type   = 1'b1;
                if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
                    dec_valid = 1'b1;
                    dec_op    = 2'b00;
                end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
                    dec_valid = 1'b1;
                    dec_op    = 2'b01;
                end else if (funct3 == 3'b010 && funct7 == 7'b0000000) begin
                    dec_valid = 1'b1;
                    dec_op    = 2'b10;
                end else if (funct3 == 3'b000 && funct7 == 7'b0000001) begin
                    dec_valid = 1'b1;
                    dec_op    = 2'b11;
                end
            end
            OPC_I: begin
                // funct3 000..011 map straight onto the ULA operation code
                dec_cls     = CLS_ALU;
                dec_op_type = 1'b1;
                if (!funct3[2]) begin
                    dec_valid = 1'b1;
                    dec_op    = funct3[1:0];
                end
            end
            OPC_LOAD: begin
                dec_cls   = CLS_LOAD;
                dec_valid = (funct3 == 3'b011);
            end
            OPC_STORE: begin
                dec_cls   = CLS_STORE;
                dec_valid = (funct3 == 3'b011);
            end
            OPC_SYSTEM: begin
                dec_halt = (instr_q == INSTR_HALT);
            end
            default: begin
                dec_valid = 1'b0;
            end
        endcase
    end

    // Main sequencer. Outputs are computed for the state being entered, so
    // they are valid for the whole cycle of that state. ri_en for the next
    // instruction is decided by run on the edge that enters (or stays in)
    // FETCH; once ri_en is up the FETCH cycle always hands off to DECODE.
    // retired counts on the edge that closes the pc_en cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= FETCH;
            cls            <= CLS_ALU;
            instr_q        <= '0;
            ri_en          <= 1'b0;
            pc_en          <= 1'b0;
            load_en        <= 1'b0;
            store_en       <= 1'b0;
            op_ula         <= 2'b00;
            operation_type <= 1'b0;
            ula_entry      <= 1'b0;
            halted         <= 1'b0;
            illegal        <= 1'b0;
            retired        <= '0;
        end else begin
            ri_en    <= 1'b0;
            pc_en    <= 1'b0;
            load_en  <= 1'b0;
            store_en <= 1'b0;
            if (pc_en) begin
                retired <= retired + CNT_BITS'(1);
            end
            case (state)
                FETCH: begin
                    if (ri_en) begin
                        instr_q <= instrucao;
                        state   <= DECODE;
                    end else begin
                        ri_en <= run;
                    end
                end
                DECODE: begin
                    if (dec_halt) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else if (dec_valid) begin
                        state          <= EXEC;
                        cls            <= dec_cls;
                        op_ula         <= dec_op;
                        ula_entry      <= dec_ula_entry;
                        operation_type <= dec_op_type;
                    end else begin
                        state   <= ERROR;
                        illegal <= 1'b1;
                    end
                end
                EXEC: begin
                    if (cls == CLS_ALU) begin
                        state   <= WB;
                        load_en <= 1'b1;
                        pc_en   <= 1'b1;
                    end else begin
                        // STORE retires in MEM; LOAD waits for WB
                        state    <= MEM;
                        store_en <= (cls == CLS_STORE);
                        pc_en    <= (cls == CLS_STORE);
                    end
                end
                MEM: begin
                    if (cls == CLS_LOAD) begin
                        state   <= WB;
                        load_en <= 1'b1;
                        pc_en   <= 1'b1;
                    end else begin
                        state          <= FETCH;
                        op_ula         <= 2'b00;
                        ula_entry      <= 1'b0;
                        operation_type <= 1'b0;
                        ri_en          <= run;
                    end
                end
                WB: begin
                    state          <= FETCH;
                    op_ula         <= 2'b00;
                    ula_entry      <= 1'b0;
                    operation_type <= 1'b0;
                    ri_en          <= run;
                end
                HALT: begin
                    state <= HALT;
                end
                ERROR: begin
                    state <= ERROR;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// ---------------------------------------------------------------------------
// tb_unidade_controle_multiciclo
//
// Drives directed and random instruction streams into the control unit and
// compares every cycle's outputs against a table-driven reference model:
// instructions are classified by mask/match patterns, and each class has a
// fixed per-cycle output profile counted from its ri_en cycle.
// ---------------------------------------------------------------------------
module tb_unidade_controle_multiciclo;

    localparam int TB_CNT = 4;

    // Reference decode table: class 0 R-ALU, 1 I-ALU, 2 LOAD, 3 STORE, 4 HALT
    localparam logic [31:0] PAT_MASK [11] = '{
        32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
        32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F,
        32'h0000707F, 32'h0000707F, 32'hFFFFFFFF};
    localparam logic [31:0] PAT_MATCH [11] = '{
        32'h00000033, 32'h40000033, 32'h00002033, 32'h02000033,
        32'h00000013, 32'h00001013, 32'h00002013, 32'h00003013,
        32'h00003003, 32'h00003023, 32'h00000073};
    localparam int PAT_CLS [11] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 3, 4};
    localparam logic [1:0] PAT_OP [11] = '{2'd0, 2'd1, 2'd2, 2'd3,
                                           2'd0, 2'd1, 2'd2, 2'd3,
                                           2'd0, 2'd0, 2'd0};

    logic              clk = 1'b0;
    logic              reset;
    logic              run;
    logic [31:0]       instrucao;
    logic              ri_en;
    logic              pc_en;
    logic              load_en;
    logic              store_en;
    logic [1:0]        op_ula;
    logic              operation_type;
    logic              ula_entry;
    logic              halted;
    logic              illegal;
    logic [TB_CNT-1:0] retired;
    logic [9:0]        obs;

    int errors = 0;
    int checks = 0;
    int retired_model = 0;

    always #5 clk = ~clk;

    unidade_controle_multiciclo #(.CNT_BITS(TB_CNT)) dut (
        .clk            (clk),
        .reset          (reset),
        .run            (run),
        .instrucao      (instrucao),
        .ri_en          (ri_en),
        .pc_en          (pc_en),
        .load_en        (load_en),
        .store_en       (store_en),
        .op_ula         (op_ula),
        .operation_type (operation_type),
        .ula_entry      (ula_entry),
        .halted         (halted),
        .illegal        (illegal),
        .retired        (retired)
    );

    // Bit layout: 9 ri_en, 8 pc_en, 7 load_en, 6 store_en, 5:4 op_ula,
    // 3 operation_type, 2 ula_entry, 1 halted, 0 illegal
    assign obs = {ri_en, pc_en, load_en, store_en, op_ula,
                  operation_type, ula_entry, halted, illegal};

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic void classify(input logic [31:0] w, output int cls,
                                     output logic [1:0] op);
        cls = -1;
        op  = 2'd0;
        for (int i = 0; i < 11; i++) begin
            if (cls == -1 && (w & PAT_MASK[i]) == PAT_MATCH[i]) begin
                cls = PAT_CLS[i];
                op  = PAT_OP[i];
            end
        end
    endfunction

    // Expected control vector for cycle k counted from the ri_en cycle
    function automatic logic [9:0] expVec(input int cls, input logic [1:0] op, input int k);
        logic [9:0] v;
        v = '0;
        if (k == 0) v[9] = 1'b1;
        if (k >= 2) begin
            v[5:4] = op;
            v[3]   = (cls <= 1);
            v[2]   = (cls == 0);
        end
        if (cls <= 1 && k == 3) begin
            v[8] = 1'b1;
            v[7] = 1'b1;
        end
        if (cls == 3 && k == 3) begin
            v[8] = 1'b1;
            v[6] = 1'b1;
        end
        if (cls == 2 && k == 4) begin
            v[8] = 1'b1;
            v[7] = 1'b1;
        end
        return v;
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkCycle(input string tag, input logic [9:0] exp_v, input logic [9:0] mask);
        checkOutput({tag, " ctl"}, 32'(obs & mask), 32'(exp_v & mask));
        checkOutput({tag, " retired"}, 32'(retired), 32'(retired_model));
    endtask

    // Runs one legal instruction starting in its ri_en cycle; abort_k >= 0
    // returns right after checking that cycle, leaving the instruction open.
    task automatic applyStimulus(input logic [31:0] w, input string name,
                                 input logic next_run, input int abort_k);
        int         cls;
        logic [1:0] op;
        int         len;
        logic [9:0] mask;
        classify(w, cls, op);
        len  = (cls == 2) ? 5 : 4;
        mask = (cls == 3) ? 10'h3F7 : 10'h3FF;
        for (int k = 0; k < len; k++) begin
            checkCycle($sformatf("%s k%0d", name, k), expVec(cls, op, k), mask);
            if (k == abort_k) return;
            instrucao = (k == 0) ? w : $urandom;
            if (k == 0)            run = 1'b1;
            else if (k == len - 1) run = next_run;
            else                   run = 1'($urandom_range(0, 1));
            nextCycle();
        end
        retired_model = (retired_model + 1) % (1 << TB_CNT);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            checkCycle("idle", 10'h000, 10'h3FF);
            run       = (i == n - 1);
            instrucao = $urandom;
            nextCycle();
        end
    endtask

    task automatic runTrap(input logic [31:0] w, input string name);
        int         cls;
        logic [1:0] op;
        logic [9:0] trap_v;
        classify(w, cls, op);
        trap_v = (cls == 4) ? 10'h002 : 10'h001;
        checkCycle({name, " k0"}, 10'h200, 10'h3FF);
        instrucao = w;
        run       = 1'b1;
        nextCycle();
        checkCycle({name, " k1"}, 10'h000, 10'h3FF);
        run       = 1'($urandom_range(0, 1));
        instrucao = $urandom;
        nextCycle();
        for (int k = 2; k < 8; k++) begin
            checkCycle($sformatf("%s k%0d", name, k), trap_v, 10'h3FF);
            run       = 1'($urandom_range(0, 1));
            instrucao = $urandom;
            nextCycle();
        end
    endtask

    task automatic pulseReset();
        reset = 1'b0;
        run   = 1'b0;
        #1;
        retired_model = 0;
        checkCycle("reset_low", 10'h000, 10'h3FF);
        nextCycle();
        checkCycle("reset_hold", 10'h000, 10'h3FF);
        reset = 1'b1;
        #1;
        idle(2);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] w;
        int          c;
        logic [1:0]  o;
        logic        nr;

        reset     = 1'b0;
        run       = 1'b0;
        instrucao = '0;
        @(negedge clk);
        pulseReset();

        applyStimulus(32'h00500093, "addi", 1'b1, -1);
        applyStimulus(32'h402081B3, "sub", 1'b1, -1);
        applyStimulus(32'h0020B423, "sd", 1'b1, -1);
        applyStimulus(32'h0080B203, "ld", 1'b1, -1);

        for (int n = 0; n < 60; n++) begin
            w  = PAT_MATCH[$urandom_range(0, 9)];
            classify(w, c, o);
            w  = w | ($urandom & ~PAT_MASK[c == 0 ? 0 : (c == 1 ? 4 : (c == 2 ? 8 : 9))]);
            nr = ($urandom_range(0, 3) != 0);
            applyStimulus(w, "rnd", nr, -1);
            if (!nr) idle($urandom_range(1, 3));
        end

        // Reset lands in the middle of a store's MEM cycle
        applyStimulus(32'h0020B423, "sd_abort", 1'b1, 3);
        #2;
        reset = 1'b0;
        run   = 1'b0;
        #1;
        retired_model = 0;
        checkCycle("async_rst", 10'h000, 10'h3FF);
        nextCycle();
        checkCycle("rst_held", 10'h000, 10'h3FF);
        reset = 1'b1;
        #1;
        idle(3);
        applyStimulus(32'h00500093, "addi2", 1'b1, -1);
        runTrap(32'h0000007F, "illegal");

        pulseReset();
        applyStimulus(32'h00500093, "addi3", 1'b1, -1);
        runTrap(32'h00000073, "halt");

        pulseReset();
        w = 32'h0000007F;
        for (int t = 0; t < 1000; t++) begin
            w = $urandom;
            classify(w, c, o);
            if (c == -1) break;
        end
        runTrap(w, "rnd_illegal");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
